// File: rtl/ha_array_pkg.sv
// Shared types and constants for the half-adder array accumulator.
package ha_array_pkg;

  localparam int GROUPS = 4;
  localparam int T_W    = 9;
  localparam int B_W    = 7;
  localparam int ACC_W  = 17;

  typedef struct packed {
    logic [T_W-1:0] t;
    logic [B_W-1:0] b;
  } ha_group_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ha_array_accumulator_weight.sv
// Combinational weighting of one row-pair group: (t + (b << 2)) << (2 * idx).
module ha_group_weight
  import ha_array_pkg::*;
(
  input  logic [T_W-1:0]   t_i,
  input  logic [B_W-1:0]   b_i,
  input  logic [1:0]       idx_i,
  output logic [ACC_W-1:0] w_o
);

  logic [10:0] g;

  // g peaks at 1019, so the largest shift (6) still fits in ACC_W bits
  assign g   = {2'b00, t_i} + {2'b00, b_i, 2'b00};
  assign w_o = {6'b000000, g} << {idx_i, 1'b0};

endmodule

// File: rtl/ha_array_accumulator.sv
// Captures four row-pair groups, accumulates their weighted values over four
// cycles with one shared adder, and returns a saturated 16-bit product.
module ha_array_accumulator
  import ha_array_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [T_W-1:0] ha_array_0_t,
  input  logic [B_W-1:0] ha_array_0_b,
  input  logic [T_W-1:0] ha_array_1_t,
  input  logic [B_W-1:0] ha_array_1_b,
  input  logic [T_W-1:0] ha_array_2_t,
  input  logic [B_W-1:0] ha_array_2_b,
  input  logic [T_W-1:0] ha_array_3_t,
  input  logic [B_W-1:0] ha_array_3_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [15:0]    product,
  output logic           ovf
);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [1:0]       cnt_q, cnt_d;
  ha_group_t        hold_q [GROUPS];
  ha_group_t        hold_d [GROUPS];
  ha_group_t        in_group [GROUPS];
  logic [ACC_W-1:0] w_sel;

  assign in_group[0] = '{t: ha_array_0_t, b: ha_array_0_b};
  assign in_group[1] = '{t: ha_array_1_t, b: ha_array_1_b};
  assign in_group[2] = '{t: ha_array_2_t, b: ha_array_2_b};
  assign in_group[3] = '{t: ha_array_3_t, b: ha_array_3_b};

  // Single shared weighting stage, steered by the cycle counter
  ha_group_weight u_weight (
    .t_i   (hold_q[cnt_q].t),
    .b_i   (hold_q[cnt_q].b),
    .idx_i (cnt_q),
    .w_o   (w_sel)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < GROUPS; i++) hold_d[i] = hold_q[i];
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          for (int i = 0; i < GROUPS; i++) hold_d[i] = in_group[i];
          acc_d   = '0;
          cnt_d   = 2'd0;
          state_d = ACC;
        end
      end
      ACC: begin
        acc_d = acc_q + w_sel;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= 2'd0;
      for (int i = 0; i < GROUPS; i++) hold_q[i] <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < GROUPS; i++) hold_q[i] <= hold_d[i];
    end
  end

  // Saturation happens only here; the accumulator itself never wraps
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign product   = !out_valid ? 16'h0000 :
                     (acc_q > 17'h0FFFF) ? 16'hFFFF : acc_q[15:0];
  assign ovf       = out_valid & acc_q[16];

endmodule

// File: tb/tb_ha_array_accumulator.sv
// Directed-vector bench for ha_array_accumulator with hand-computed results.
module tb_ha_array_accumulator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [8:0] tv [4];
  logic [6:0] bv [4];
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [15:0] product;
  logic       ovf;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ha_array_accumulator dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ha_array_0_t (tv[0]),
    .ha_array_0_b (bv[0]),
    .ha_array_1_t (tv[1]),
    .ha_array_1_b (bv[1]),
    .ha_array_2_t (tv[2]),
    .ha_array_2_b (bv[2]),
    .ha_array_3_t (tv[3]),
    .ha_array_3_b (bv[3]),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product),
    .ovf          (ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic set_vec(input logic [8:0] t0, input logic [6:0] b0,
                         input logic [8:0] t1, input logic [6:0] b1,
                         input logic [8:0] t2, input logic [6:0] b2,
                         input logic [8:0] t3, input logic [6:0] b3);
    tv[0] = t0; bv[0] = b0; tv[1] = t1; bv[1] = b1;
    tv[2] = t2; bv[2] = b2; tv[3] = t3; bv[3] = b3;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic accept_beat(input string tag);
    int n = 0;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check({tag, "_accept_timeout"}, 0, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    $display("beat %s accepted at %0t", tag, $time);
  endtask

  // Called at the negedge after acceptance; waits for the result
  task automatic collect(input string tag, input logic [15:0] exp_p, input logic exp_o);
    int lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, 4);
    check({tag, "_product"}, product, exp_p);
    check({tag, "_ovf"}, ovf, exp_o);
    $display("result %s: product=%0d ovf=%0d latency=%0d", tag, product, ovf, lat);
    if (out_ready) begin
      @(negedge clk);
      check({tag, "_idle"}, {out_valid, in_ready}, 2'b01);
    end
  endtask

  initial begin
    // Reset values, with in_valid already high across release
    set_vec(0, 0, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b1;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_product", product, 0);
    check("rst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    accept_beat("zero");
    collect("zero", 16'd0, 1'b0);

    @(negedge clk);
    set_vec(9'h001, 0, 0, 0, 0, 0, 9'h001, 0);
    accept_beat("g0g3");
    collect("g0g3", 16'd65, 1'b0);

    @(negedge clk);
    set_vec(0, 0, 0, 7'h01, 9'h003, 0, 0, 0);
    accept_beat("g1b_g2t");
    collect("g1b_g2t", 16'd64, 1'b0);

    @(negedge clk);
    set_vec(9'h1FF, 7'h7F, 0, 0, 0, 7'h7F, 9'h100, 0);
    accept_beat("mixed");
    collect("mixed", 16'd25531, 1'b0);

    @(negedge clk);
    set_vec(9'h13F, 0, 0, 0, 0, 0, 9'h1FF, 7'h7F);
    accept_beat("edge_ffff");
    collect("edge_ffff", 16'hFFFF, 1'b0);

    @(negedge clk);
    set_vec(9'h140, 0, 0, 0, 0, 0, 9'h1FF, 7'h7F);
    accept_beat("edge_10000");
    collect("edge_10000", 16'hFFFF, 1'b1);

    @(negedge clk);
    set_vec(9'h1FF, 7'h7F, 9'h1FF, 7'h7F, 9'h1FF, 7'h7F, 9'h1FF, 7'h7F);
    accept_beat("all_ones");
    collect("all_ones", 16'hFFFF, 1'b1);

    // Backpressure: hold out_ready low while new inputs are presented
    @(negedge clk);
    out_ready = 1'b0;
    set_vec(9'h001, 0, 0, 0, 0, 0, 9'h001, 0);
    accept_beat("bp");
    collect("bp", 16'd65, 1'b0);
    set_vec(9'h005, 0, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_product", product, 16'd65);
      check("bp_hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_idle", {out_valid, in_ready}, 2'b01);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_next_accepted", in_ready, 0);
    collect("bp_next", 16'd5, 1'b0);

    // Reset in the middle of accumulation
    @(negedge clk);
    set_vec(9'h1FF, 7'h7F, 9'h1FF, 7'h7F, 9'h1FF, 7'h7F, 9'h1FF, 7'h7F);
    accept_beat("abort");
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_product", product, 0);
    rst_n = 1'b1;
    set_vec(0, 0, 0, 7'h01, 9'h003, 0, 0, 0);
    accept_beat("post_abort");
    collect("post_abort", 16'd64, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ha_array_accumulator.md
# ha_array_accumulator

Sequential reducer on the consuming side of the half-adder partial-product array. It accepts one beat of four `ha_array` row-pair groups through a valid/ready handshake. Each group holds a top vector `t` and a bottom vector `b`. The block weights the four groups and accumulates them over four cycles with one shared adder, then returns a 16-bit product through a second valid/ready handshake. It sits between the approximate partial-product generators and downstream datapath or error-measurement logic.

## Interface
- `GROUPS`, 4: number of row-pair groups; group k carries weight 2^(2k).
- `T_W`, 9: width of each `t` vector.
- `B_W`, 7: width of each `b` vector.
- `ACC_W`, 17: accumulator width.
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `in_valid` input 1: the groups below are valid.
- `in_ready` output 1: the block can accept a beat.
- `ha_array_k_t` input `T_W`, for k=0..3: top vector of group k; bit i has weight 2k+i.
- `ha_array_k_b` input `B_W`, for k=0..3: bottom vector of group k; bit i has weight 2k+i+2.
- `out_valid` output 1: `product` and `ovf` are valid.
- `out_ready` input 1: the downstream consumer accepts the result.
- `product` output 16: saturated sum of all weighted groups.
- `ovf` output 1: the unsaturated sum exceeded 16'hFFFF.

## Operation
- Group value: g_k = t_k + (b_k << 2), which is 11 bits wide with a maximum of 1019. Weighted value: w_k = g_k << (2k).
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid`&&`in_ready`, capture all 8 vectors into holding registers, clear the accumulator, set `cnt`=0 and go to ACC.
  - ACC: each cycle, acc <= acc + w_cnt and cnt <= cnt+1. After the add with cnt=3, go to DONE.
  - DONE: `out_valid`=1. `product` = (acc > 16'hFFFF) ? 16'hFFFF : acc[15:0]. `ovf` = |acc[16]. On `out_valid`&&`out_ready`, go to IDLE.
- Width rules:
  - The accumulator is 17 bits and never wraps; the maximum sum is 1019*85 = 86615.
  - Saturation is applied only at the output.
- `in_ready` is 0 in ACC and DONE, so input beats are not pipelined.
- Input vectors are sampled only on the accepting edge; changes afterwards are ignored.

## Timing
- Reset values:
  - state=IDLE, `in_ready`=1, `out_valid`=0, `product`=0, `ovf`=0.
  - acc=0, cnt=0, holding registers=0.
- Latency:
  - Beat accepted at edge N.
  - Adds occur at edges N+1 through N+4.
  - `out_valid` rises after edge N+4.
- Throughput: at best one result every 6 cycles. The earliest next acceptance is the edge after the output handshake.
- Backpressure: while `out_ready`=0 in DONE, `product`, `ovf` and `out_valid` are held stable.
- Output handshake and `in_valid` on the same edge:
  - The output handshake moves the FSM to IDLE only.
  - The new beat is accepted on a later edge, once `in_ready`=1.
- Reset asserted mid-ACC or in DONE:
  - Immediate return to reset values.
  - A partial result is never emitted.
- `in_valid` held high across reset release: the beat is accepted on the first edge after `rst_n` deasserts.

## Structure
- Shared package `ha_array_pkg`:
  - `T_W`, `B_W`, `GROUPS`, `ACC_W` constants.
  - `ha_group_t` struct with fields `t` and `b`.
  - FSM state enum with values IDLE, ACC and DONE.
- Sub-module `ha_group_weight`: combinational; takes `t`, `b` and a 2-bit group index and produces the `ACC_W`-bit w_k. It is instantiated once, fed through a `cnt`-driven mux over the holding registers.

## Test plan
- All vectors zero, then `in_valid` pulsed with `out_ready`=1 -> `product`=0 and `ovf`=0, with `out_valid` rising 4 cycles after acceptance.
- Group 0 `t`=9'h001 and group 3 `t`=9'h001, all else zero -> `product`=65 (1+64), `ovf`=0.
- Group 1 `b`=7'h01 and group 2 `t`=9'h003, all else zero -> `product`=16+48=64.
- All vectors all-ones -> sum 86615, so `product`=16'hFFFF and `ovf`=1.
- `out_ready` held low for 3 cycles in DONE, with the input vectors changed and `in_valid` high during that time -> output stays stable and `in_ready`=0. After `out_ready` rises, IDLE is entered and the new beat is accepted one edge later.
- `rst_n` asserted during ACC cycle 2 -> `out_valid`=0 and `in_ready`=1 after reset. The next beat yields the correct sum with no contribution left over from the aborted beat.
